// File: rtl/tcd_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tcd_pkg : shared types and constants for the TCD command scheduler |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package tcd_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_WAIT  = 3'd2,
        ST_ACK   = 3'd3,
        ST_DRAIN = 3'd4
    } tcd_state_e;

    localparam logic [4:0] STAT_ZERO    = 5'h1E;
    localparam logic [4:0] STAT_TIMEOUT = 5'h1F;

    // Address/byte-count fields are word-granular: bus width minus the byte-lane bits.
    localparam int FIELD_W_DELTA = 2;

    function automatic logic [2:0] oh_to_idx(input logic [7:0] oh);
        logic [2:0] idx;
        idx = '0;
        for (int i = 0; i < 8; i++) begin
            if (oh[i]) idx = 3'(i);
        end
        return idx;
    endfunction

endpackage
`default_nettype wire

// File: rtl/tcd_rr_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tcd_rr_arbiter : one-hot round-robin grant starting at ptr         |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tcd_rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int PTR_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant
);

    always_comb begin
        logic             w_found;
        logic [PTR_W-1:0] w_sel;
        grant   = '0;
        w_found = 1'b0;
        w_sel   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_sel = PTR_W'((int'(ptr) + i) % NUM_REQ);
            if (!w_found && req[w_sel]) begin
                grant[w_sel] = 1'b1;
                w_found      = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/tcd_sched.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tcd_sched : shares one TCD command port among NUM_REQ requesters   |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tcd_sched
    import tcd_pkg::*;
#(
    parameter int  MEMORY_BUS_WIDTH = 32,
    parameter int  NUM_REQ          = 4,
    parameter int  TIMEOUT_CYCLES   = 1024,
    localparam int FIELD_W          = MEMORY_BUS_WIDTH - FIELD_W_DELTA,
    localparam int PTR_W            = $clog2(NUM_REQ)
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic [NUM_REQ-1:0]              rq_valid,
    input  logic [NUM_REQ-1:0][FIELD_W-1:0] rq_addr,
    input  logic [NUM_REQ-1:0][FIELD_W-1:0] rq_nbytes,
    output logic [NUM_REQ-1:0]              rq_ready,
    output logic [NUM_REQ-1:0]              rq_done,
    output logic [4:0]                      rq_status,
    output logic [FIELD_W-1:0]              addr_in,
    output logic [FIELD_W-1:0]              nbytes_in,
    output logic                            req_in,
    output logic                            ack_in,
    input  logic [4:0]                      irq_out
);

    localparam logic [15:0]      c_cnt_last = 16'(TIMEOUT_CYCLES - 1);
    localparam logic [PTR_W-1:0] c_ptr_last = PTR_W'(NUM_REQ - 1);

    tcd_state_e         r_state, w_state;
    logic [PTR_W-1:0]   r_rr_ptr, w_rr_ptr, w_gnt_idx;
    logic [15:0]        r_cnt, w_cnt;
    logic               r_req_in, w_req_in, r_ack_in, w_ack_in;
    logic               r_zero_pend, w_zero_pend;
    logic [FIELD_W-1:0] r_addr, w_addr, r_nbytes, w_nbytes;
    logic [NUM_REQ-1:0] r_rq_ready, w_rq_ready, r_rq_done, w_rq_done;
    logic [NUM_REQ-1:0] r_grant_oh, w_grant_oh, w_gnt;
    logic [4:0]         r_status, w_status;

    tcd_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_arb (
        .req   (rq_valid),
        .ptr   (r_rr_ptr),
        .grant (w_gnt)
    );

    assign w_gnt_idx = PTR_W'(oh_to_idx(8'(w_gnt)));

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_rr_ptr    <= '0;
            r_cnt       <= '0;
            r_req_in    <= 1'b0;
            r_ack_in    <= 1'b0;
            r_zero_pend <= 1'b0;
            r_addr      <= '0;
            r_nbytes    <= '0;
            r_rq_ready  <= '0;
            r_rq_done   <= '0;
            r_grant_oh  <= '0;
            r_status    <= '0;
        end else begin
            r_state     <= w_state;
            r_rr_ptr    <= w_rr_ptr;
            r_cnt       <= w_cnt;
            r_req_in    <= w_req_in;
            r_ack_in    <= w_ack_in;
            r_zero_pend <= w_zero_pend;
            r_addr      <= w_addr;
            r_nbytes    <= w_nbytes;
            r_rq_ready  <= w_rq_ready;
            r_rq_done   <= w_rq_done;
            r_grant_oh  <= w_grant_oh;
            r_status    <= w_status;
        end
    end

    always_comb begin
        w_state     = r_state;
        w_rr_ptr    = r_rr_ptr;
        w_cnt       = r_cnt;
        w_req_in    = r_req_in;
        w_ack_in    = 1'b0;
        w_zero_pend = 1'b0;
        w_addr      = r_addr;
        w_nbytes    = r_nbytes;
        w_rq_ready  = '0;
        w_rq_done   = '0;
        w_grant_oh  = r_grant_oh;
        w_status    = r_status;
        case (r_state)
            ST_IDLE: begin
                // A zero-length command finishes here; no grant in the same cycle as its done.
                if (r_zero_pend) begin
                    w_rq_done = r_grant_oh;
                    w_status  = STAT_ZERO;
                end else if ((|w_gnt) && (irq_out == 5'd0)) begin
                    w_rq_ready = w_gnt;
                    w_grant_oh = w_gnt;
                    w_rr_ptr   = (w_gnt_idx == c_ptr_last) ? '0 : w_gnt_idx + PTR_W'(1);
                    if (rq_nbytes[w_gnt_idx] == '0) begin
                        w_zero_pend = 1'b1;
                    end else begin
                        w_addr   = rq_addr[w_gnt_idx];
                        w_nbytes = rq_nbytes[w_gnt_idx];
                        w_req_in = 1'b1;
                        w_state  = ST_ISSUE;
                    end
                end
            end
            ST_ISSUE: begin
                w_cnt   = '0;
                w_state = ST_WAIT;
            end
            ST_WAIT: begin
                if ((irq_out != 5'd0) || (r_cnt == c_cnt_last)) begin
                    w_status  = (irq_out != 5'd0) ? irq_out : STAT_TIMEOUT;
                    w_req_in  = 1'b0;
                    w_ack_in  = 1'b1;
                    w_rq_done = r_grant_oh;
                    w_state   = ST_ACK;
                end else begin
                    w_cnt = r_cnt + 16'd1;
                end
            end
            ST_ACK: begin
                w_state = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (irq_out == 5'd0) w_state = ST_IDLE;
            end
            default: begin
                w_state = ST_IDLE;
            end
        endcase
    end

    assign rq_ready  = r_rq_ready;
    assign rq_done   = r_rq_done;
    assign rq_status = r_status;
    assign addr_in   = r_addr;
    assign nbytes_in = r_nbytes;
    assign req_in    = r_req_in;
    assign ack_in    = r_ack_in;

endmodule
`default_nettype wire

// File: tb/tb_tcd_sched.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_tcd_sched : directed and randomized checks of tcd_sched         |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_tcd_sched;

    localparam int N  = 4;
    localparam int BW = 32;
    localparam int FW = BW - 2;
    localparam int TO = 16;

    logic                   clock = 1'b0;
    logic                   reset;
    logic [N-1:0]           rq_valid;
    logic [N-1:0][FW-1:0]   rq_addr;
    logic [N-1:0][FW-1:0]   rq_nbytes;
    logic [N-1:0]           rq_ready;
    logic [N-1:0]           rq_done;
    logic [4:0]             rq_status;
    logic [FW-1:0]          addr_in;
    logic [FW-1:0]          nbytes_in;
    logic                   req_in;
    logic                   ack_in;
    logic [4:0]             irq_out;

    int vectors     = 0;
    int miscompares = 0;
    int ptr_model   = 0;

    tcd_sched #(
        .MEMORY_BUS_WIDTH (BW),
        .NUM_REQ          (N),
        .TIMEOUT_CYCLES   (TO)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .rq_valid  (rq_valid),
        .rq_addr   (rq_addr),
        .rq_nbytes (rq_nbytes),
        .rq_ready  (rq_ready),
        .rq_done   (rq_done),
        .rq_status (rq_status),
        .addr_in   (addr_in),
        .nbytes_in (nbytes_in),
        .req_in    (req_in),
        .ack_in    (ack_in),
        .irq_out   (irq_out)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic settle();
        repeat (3) tick();
    endtask

    // Waits (bounded) for a grant; g stays zero if none arrives.
    task automatic wait_ready(output logic [N-1:0] g, output int n);
        g = '0;
        n = 0;
        for (int i = 0; i < 20 && g == '0; i++) begin
            tick();
            n++;
            if (rq_ready !== '0) g = rq_ready;
        end
    endtask

    // Called in the grant cycle: acts as the TCD, raising code 'delay' cycles later (0 = silent).
    task automatic wait_done(input int delay, input logic [4:0] code, input bit keep,
                             output logic [N-1:0] d, output logic [4:0] s, output int req_cycles);
        d = '0;
        s = '0;
        req_cycles = 0;
        for (int i = 0; i < 60 && d == '0; i++) begin
            if (i == delay && code != 5'd0) irq_out = code;
            if (req_in === 1'b1) req_cycles++;
            tick();
            if (rq_done !== '0) begin
                d = rq_done;
                s = rq_status;
            end
        end
        if (!keep) irq_out = '0;
    endtask

    function automatic int model_grant(input logic [N-1:0] mask, input int ptr);
        for (int k = 0; k < N; k++) begin
            if (mask[(ptr + k) % N]) return (ptr + k) % N;
        end
        return -1;
    endfunction

    task automatic test_reset();
        logic [N-1:0] g;
        logic [N-1:0] d;
        logic [4:0]   s;
        int           n, rc;
        reset = 1'b1; rq_valid = '0; irq_out = 5'h01;
        rq_addr = '0; rq_nbytes = '0;
        repeat (3) tick();
        vectors++; if (rq_ready !== '0)  begin miscompares++; $display("FAIL reset_rq_ready: got %b exp 0", rq_ready); end
        vectors++; if (rq_done !== '0)   begin miscompares++; $display("FAIL reset_rq_done: got %b exp 0", rq_done); end
        vectors++; if (rq_status !== '0) begin miscompares++; $display("FAIL reset_rq_status: got %h exp 0", rq_status); end
        vectors++; if (req_in !== 1'b0)  begin miscompares++; $display("FAIL reset_req_in: got %b exp 0", req_in); end
        vectors++; if (ack_in !== 1'b0)  begin miscompares++; $display("FAIL reset_ack_in: got %b exp 0", ack_in); end
        vectors++; if (addr_in !== '0)   begin miscompares++; $display("FAIL reset_addr_in: got %h exp 0", addr_in); end
        vectors++; if (nbytes_in !== '0) begin miscompares++; $display("FAIL reset_nbytes_in: got %h exp 0", nbytes_in); end
        reset = 1'b0;
        rq_valid = 4'b0001; rq_nbytes[0] = 30'd8;
        for (int i = 0; i < 4; i++) begin
            tick();
            vectors++; if (rq_ready !== '0) begin miscompares++; $display("FAIL post_reset_drain: got %b exp 0", rq_ready); end
        end
        irq_out = '0;
        wait_ready(g, n);
        rq_valid = '0;
        vectors++; if (g !== 4'b0001) begin miscompares++; $display("FAIL post_reset_grant: got %b exp 0001", g); end
        wait_done(2, 5'h03, 1'b0, d, s, rc);
        vectors++; if (d !== 4'b0001 || s !== 5'h03) begin miscompares++; $display("FAIL post_reset_done: got %b/%h exp 0001/03", d, s); end
        ptr_model = 1;
        settle();
    endtask

    task automatic test_basic();
        logic [N-1:0] g;
        logic [N-1:0] d;
        logic [4:0]   s;
        int           n, rc;
        rq_valid = 4'b0001; rq_addr[0] = 30'h100; rq_nbytes[0] = 30'd64;
        wait_ready(g, n);
        rq_valid = '0;
        vectors++; if (g !== 4'b0001) begin miscompares++; $display("FAIL basic_grant: got %b exp 0001", g); end
        vectors++; if (n !== 1) begin miscompares++; $display("FAIL basic_latency: got %0d exp 1", n); end
        vectors++; if (req_in !== 1'b1 || addr_in !== 30'h100 || nbytes_in !== 30'd64) begin
            miscompares++; $display("FAIL basic_cmd: got req=%b addr=%h nb=%0d exp 1/100/64", req_in, addr_in, nbytes_in);
        end
        wait_done(10, 5'h01, 1'b0, d, s, rc);
        vectors++; if (rc !== 11) begin miscompares++; $display("FAIL basic_req_cycles: got %0d exp 11", rc); end
        vectors++; if (d !== 4'b0001 || s !== 5'h01) begin miscompares++; $display("FAIL basic_done: got %b/%h exp 0001/01", d, s); end
        vectors++; if (ack_in !== 1'b1 || req_in !== 1'b0) begin miscompares++; $display("FAIL basic_ack: got ack=%b req=%b exp 1/0", ack_in, req_in); end
        tick();
        vectors++; if (ack_in !== 1'b0 || rq_done !== '0) begin miscompares++; $display("FAIL basic_ack_pulse: got ack=%b done=%b exp 0/0", ack_in, rq_done); end
        ptr_model = 1;
        settle();
    endtask

    task automatic test_round_robin();
        logic [N-1:0] g;
        logic [N-1:0] d;
        logic [N-1:0] e;
        logic [4:0]   s;
        int           n, rc;
        reset = 1'b1; tick(); reset = 1'b0;
        for (int j = 0; j < N; j++) rq_nbytes[j] = 30'd4;
        rq_valid = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            wait_ready(g, n);
            if (k == 4) rq_valid = '0;
            e = '0; e[k % N] = 1'b1;
            vectors++; if (g !== e) begin miscompares++; $display("FAIL rr_grant%0d: got %b exp %b", k, g, e); end
            wait_done(1, 5'h02, 1'b0, d, s, rc);
            vectors++; if (d !== e) begin miscompares++; $display("FAIL rr_done%0d: got %b exp %b", k, d, e); end
        end
        ptr_model = 1;
        settle();
    endtask

    task automatic test_zero();
        logic [N-1:0] g;
        int           n;
        rq_valid = 4'b0100; rq_nbytes[2] = '0; rq_addr[2] = 30'h55;
        wait_ready(g, n);
        rq_valid = '0;
        vectors++; if (g !== 4'b0100 || req_in !== 1'b0) begin miscompares++; $display("FAIL zero_grant: got %b req=%b exp 0100/0", g, req_in); end
        tick();
        vectors++; if (rq_done !== 4'b0100 || rq_status !== 5'h1E) begin miscompares++; $display("FAIL zero_done: got %b/%h exp 0100/1e", rq_done, rq_status); end
        vectors++; if (req_in !== 1'b0 || ack_in !== 1'b0 || rq_ready !== '0) begin
            miscompares++; $display("FAIL zero_quiet: got req=%b ack=%b rdy=%b exp 0/0/0", req_in, ack_in, rq_ready);
        end
        rq_nbytes[2] = 30'd4;
        ptr_model = 3;
        settle();
    endtask

    task automatic test_timeout();
        logic [N-1:0] g;
        logic [N-1:0] d;
        logic [4:0]   s;
        int           n, rc;
        rq_valid = 4'b0010;
        wait_ready(g, n);
        rq_valid = '0;
        vectors++; if (g !== 4'b0010) begin miscompares++; $display("FAIL to_grant: got %b exp 0010", g); end
        wait_done(0, 5'h00, 1'b0, d, s, rc);
        vectors++; if (rc !== TO + 1) begin miscompares++; $display("FAIL to_req_cycles: got %0d exp %0d", rc, TO + 1); end
        vectors++; if (d !== 4'b0010 || s !== 5'h1F || req_in !== 1'b0) begin
            miscompares++; $display("FAIL to_done: got %b/%h req=%b exp 0010/1f/0", d, s, req_in);
        end
        ptr_model = 2;
        settle();
    endtask

    task automatic test_drain();
        logic [N-1:0] g;
        logic [N-1:0] d;
        logic [4:0]   s;
        int           n, rc;
        rq_valid = 4'b0001;
        wait_ready(g, n);
        rq_valid = 4'b0010;
        vectors++; if (g !== 4'b0001) begin miscompares++; $display("FAIL drain_grant0: got %b exp 0001", g); end
        wait_done(3, 5'h01, 1'b1, d, s, rc);
        vectors++; if (d !== 4'b0001 || s !== 5'h01) begin miscompares++; $display("FAIL drain_done0: got %b/%h exp 0001/01", d, s); end
        for (int i = 0; i < 5; i++) begin
            tick();
            vectors++; if (rq_ready !== '0 || rq_done !== '0) begin
                miscompares++; $display("FAIL drain_hold%0d: got rdy=%b done=%b exp 0/0", i, rq_ready, rq_done);
            end
        end
        irq_out = '0;
        wait_ready(g, n);
        rq_valid = '0;
        vectors++; if (g !== 4'b0010) begin miscompares++; $display("FAIL drain_grant1: got %b exp 0010", g); end
        wait_done(2, 5'h04, 1'b0, d, s, rc);
        vectors++; if (d !== 4'b0010 || s !== 5'h04) begin miscompares++; $display("FAIL drain_done1: got %b/%h exp 0010/04", d, s); end
        ptr_model = 2;
        settle();
        irq_out = 5'h07;
        for (int i = 0; i < 3; i++) begin
            tick();
            vectors++; if (rq_done !== '0 || ack_in !== 1'b0) begin miscompares++; $display("FAIL idle_irq%0d: got done=%b ack=%b exp 0/0", i, rq_done, ack_in); end
        end
        irq_out = '0;
        settle();
    endtask

    task automatic test_reset_mid();
        logic [N-1:0] g;
        logic [N-1:0] d;
        logic [4:0]   s;
        int           n, rc;
        rq_valid = 4'b1000;
        wait_ready(g, n);
        rq_valid = '0;
        vectors++; if (g !== 4'b1000) begin miscompares++; $display("FAIL rst_mid_grant: got %b exp 1000", g); end
        repeat (3) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        vectors++; if ({rq_ready, rq_done, rq_status, req_in, ack_in} !== '0 || addr_in !== '0 || nbytes_in !== '0) begin
            miscompares++; $display("FAIL rst_mid_outputs: got rdy=%b done=%b st=%h req=%b ack=%b addr=%h nb=%h exp all 0",
                                    rq_ready, rq_done, rq_status, req_in, ack_in, addr_in, nbytes_in);
        end
        for (int i = 0; i < 5; i++) begin
            tick();
            vectors++; if (rq_done !== '0) begin miscompares++; $display("FAIL rst_mid_nodone%0d: got %b exp 0", i, rq_done); end
        end
        rq_valid = 4'b0110;
        wait_ready(g, n);
        rq_valid = '0;
        vectors++; if (g !== 4'b0010) begin miscompares++; $display("FAIL rst_mid_next_grant: got %b exp 0010", g); end
        wait_done(4, 5'h09, 1'b0, d, s, rc);
        vectors++; if (d !== 4'b0010 || s !== 5'h09) begin miscompares++; $display("FAIL rst_mid_next_done: got %b/%h exp 0010/09", d, s); end
        ptr_model = 2;
        settle();
    endtask

    task automatic test_random();
        logic [N-1:0]  mask, g, d, e;
        logic [4:0]    s, code;
        logic [FW-1:0] ea, en;
        int            n, rc, idx, delay;
        for (int it = 0; it < 40; it++) begin
            mask = N'($urandom_range(15, 1));
            for (int j = 0; j < N; j++) begin
                rq_addr[j]   = FW'($urandom);
                rq_nbytes[j] = ($urandom_range(4, 0) == 0) ? '0 : FW'($urandom_range(4096, 1));
            end
            idx = model_grant(mask, ptr_model);
            e = '0; e[idx] = 1'b1;
            ea = rq_addr[idx];
            en = rq_nbytes[idx];
            rq_valid = mask;
            wait_ready(g, n);
            rq_valid = '0;
            vectors++; if (g !== e) begin miscompares++; $display("FAIL rnd_grant%0d: got %b exp %b", it, g, e); end
            if (en == '0) begin
                vectors++; if (req_in !== 1'b0) begin miscompares++; $display("FAIL rnd_zero_req%0d: got %b exp 0", it, req_in); end
                tick();
                vectors++; if (rq_done !== e || rq_status !== 5'h1E) begin
                    miscompares++; $display("FAIL rnd_zero_done%0d: got %b/%h exp %b/1e", it, rq_done, rq_status, e);
                end
            end else begin
                vectors++; if (req_in !== 1'b1 || addr_in !== ea || nbytes_in !== en) begin
                    miscompares++; $display("FAIL rnd_cmd%0d: got req=%b addr=%h nb=%h exp 1/%h/%h", it, req_in, addr_in, nbytes_in, ea, en);
                end
                delay = $urandom_range(12, 0);
                code  = 5'($urandom_range(31, 1));
                wait_done(delay, code, 1'b0, d, s, rc);
                vectors++; if (d !== e || s !== code) begin
                    miscompares++; $display("FAIL rnd_done%0d: got %b/%h exp %b/%h", it, d, s, e, code);
                end
            end
            ptr_model = (idx + 1) % N;
        end
        settle();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_round_robin();
        test_zero();
        test_timeout();
        test_drain();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

endmodule
`default_nettype wire
